rvm_mem_responder: RTL
======================

Name: rvm_mem_responder

Overview:
- Memory-side responder for the rvm_control memory request interface.
- Holds a word-addressed backing store and answers one read or write request at a time.
- Configurable wait states, byte-strobe writes, and registered read data.
- Used as on-chip instruction/data memory in the system top and as the memory model in core-level benches.

Parameters:
DEPTH, 1024, number of 32-bit words in the backing store (power of two, >= 4)
WAIT_CYCLES, 2, extra cycles inserted between request acceptance and response (0..255)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be DEPTH*4 aligned

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
mem_req  input  1  request valid; held high with stable fields until mem_ack
mem_wen  input  1  1 = write, 0 = read
mem_addr  input  32  byte address
mem_wdata  input  32  write data
mem_strb  input  4  byte write enables; bit i covers wdata[8i+7:8i]
mem_ack  output  1  one-cycle response strobe
mem_rdata  output  32  read data; valid only while mem_ack=1
mem_error  output  1  response is an error; valid only while mem_ack=1

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous, active-low on resetn.
- Reset values: mem_ack=0, mem_rdata=0, mem_error=0, state=IDLE, wait counter=0. Backing store is not reset.
- States:
  - IDLE: if mem_req, capture wen/addr/wdata/strb. Go to WAIT if WAIT_CYCLES>0, else to RESP.
  - WAIT: counter counts 1..WAIT_CYCLES. Go to RESP on the edge where counter==WAIT_CYCLES.
  - RESP: mem_ack=1 for exactly one cycle, then IDLE.
- Latency: ack is high in cycle N+WAIT_CYCLES+1 when the request is accepted at edge N. Minimum 1 cycle when WAIT_CYCLES=0.
- Throughput: a new request is accepted no earlier than the edge after the ack cycle, so there is one IDLE bubble between transactions.
- Address decode:
  - offset = addr - BASE_ADDR (32-bit wrap).
  - index = offset[log2(DEPTH)+1:2].
  - Out of range when offset >= DEPTH*4, including addr < BASE_ADDR through wrap.
- Commit point: on the edge entering RESP.
  - Read: mem_rdata <= store[index].
  - Write: for each set strb bit, the store byte is updated. mem_rdata <= 0.
  - strb=0 write: no store change, ack with no error.
- mem_rdata and mem_error are forced to 0 on the edge leaving RESP.
- Ordering: a read following a write to the same word returns the written data, because the write commits before the next accept.
- mem_req dropped before ack: this is a protocol violation. The captured transaction still completes and acks. With RVM_SIM_ASSERT defined, an assertion fires.
- Reset mid-transaction: returns to IDLE immediately; any uncommitted write is discarded.

Optional Feature:
- Macro: RVM_MEM_RESP_ERR_EN.
- Defined:
  - Out-of-range or addr[1:0]!=0 sets mem_error=1 in RESP.
  - No write is performed and mem_rdata=0.
- Undefined:
  - mem_error is tied to 0.
  - addr[1:0] is ignored.
  - The index wraps modulo DEPTH; out-of-range accesses alias.

Decomposition:
- rvm_constants.v:
  - RVM_MEMR_IDLE/WAIT/RESP state encodings (2 bits).
  - RVM_MEM_WORD_W=32 and RVM_MEM_STRB_W=4.
- Sub-module rvm_mem_array (DEPTH x 32 store, registered read, byte-strobed write, one port). Keeps the store inferable as block RAM.
- FSM, wait counter and decode stay in rvm_mem_responder.

Test Plan:
1. Reset, WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, strb 4'hF, then read 0x10. Each ack arrives 3 cycles after accept; rdata=0xDEADBEEF, error=0.
2. Write 0xAABBCCDD to 0x20 with strb 4'hF, then write 0x11223344 with strb 4'b0101. Read of 0x20 returns 0xAA22CC44.
3. WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 with req held high. Acks occur 2 cycles apart, each 1 cycle after its accept; exactly one ack per request.
4. With ERR_EN: read 0x1002 (misaligned) and read DEPTH*4 (out of range). Both give ack with error=1, rdata=0. A write to DEPTH*4 leaves word 0 unchanged.
5. Without ERR_EN, DEPTH=1024: write 0x55 to 0x1000, then read 0x0. Returns 0x00000055 (alias).
6. Assert resetn=0 during WAIT of a write to 0x30 holding 0x0. No ack; state is IDLE after release; a later read of 0x30 returns 0x0.

Source files
------------

// File: rtl/rvm_mem_responder_pkg.sv
// rtl/rvm_mem_responder_pkg.sv - shared widths and FSM state encodings for the memory responder
// Word/strobe widths and the 2-bit responder state type.
package rvm_mem_responder_pkg;

  localparam int RVM_MEM_WORD_W = 32;
  localparam int RVM_MEM_STRB_W = 4;

  typedef enum logic [1:0] {
    RVM_MEMR_IDLE = 2'd0,
    RVM_MEMR_WAIT = 2'd1,
    RVM_MEMR_RESP = 2'd2
  } rvm_memr_state_e;

endpackage

// File: rtl/rvm_mem_array.sv
// rtl/rvm_mem_array.sv - single-port word store with byte-strobed write and registered read
// No reset on the store or read register so the array maps onto block RAM.
module rvm_mem_array
  import rvm_mem_responder_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      i_en,
  input  logic                      i_we,
  input  logic [AW-1:0]             i_idx,
  input  logic [RVM_MEM_WORD_W-1:0] i_wdata,
  input  logic [RVM_MEM_STRB_W-1:0] i_strb,
  output logic [RVM_MEM_WORD_W-1:0] o_rdata
);

  logic [RVM_MEM_WORD_W-1:0] r_mem [DEPTH];
  logic [RVM_MEM_WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < RVM_MEM_STRB_W; b++) begin
          if (i_strb[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rvm_mem_responder.sv
// rtl/rvm_mem_responder.sv - wait-stated memory responder for the rvm_control request interface
// Optional error responses (out-of-range / misaligned) with RVM_MEM_RESP_ERR_EN; protocol check with RVM_SIM_ASSERT.
module rvm_mem_responder
  import rvm_mem_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      mem_req,
  input  logic                      mem_wen,
  input  logic [31:0]               mem_addr,
  input  logic [RVM_MEM_WORD_W-1:0] mem_wdata,
  input  logic [RVM_MEM_STRB_W-1:0] mem_strb,
  output logic                      mem_ack,
  output logic [RVM_MEM_WORD_W-1:0] mem_rdata,
  output logic                      mem_error
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES);
`ifdef RVM_MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  rvm_memr_state_e           r_state, w_next;
  logic [7:0]                r_cnt;
  logic                      r_wen, r_rd_ok, r_err;
  logic [31:0]               r_addr;
  logic [RVM_MEM_WORD_W-1:0] r_wdata, w_q;
  logic [RVM_MEM_STRB_W-1:0] r_strb;

  logic                      w_idle, w_wen, w_oor, w_misal, w_err, w_commit;
  logic [31:0]               w_addr, w_offset;
  logic [RVM_MEM_WORD_W-1:0] w_wdata;
  logic [RVM_MEM_STRB_W-1:0] w_strb;

  // With no wait states the commit edge is the accept edge, so decode must see the live request.
  assign w_idle   = (r_state == RVM_MEMR_IDLE);
  assign w_wen    = w_idle ? mem_wen   : r_wen;
  assign w_addr   = w_idle ? mem_addr  : r_addr;
  assign w_wdata  = w_idle ? mem_wdata : r_wdata;
  assign w_strb   = w_idle ? mem_strb  : r_strb;
  assign w_offset = w_addr - BASE_ADDR;
  assign w_oor    = |w_offset[31:AW+2];
  assign w_misal  = |w_offset[1:0];
  assign w_err    = ERR_EN && (w_oor || w_misal);
  assign w_commit = resetn && (w_next == RVM_MEMR_RESP) && (r_state != RVM_MEMR_RESP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= RVM_MEMR_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    mem_ack = 1'b0;
    case (r_state)
      RVM_MEMR_IDLE: if (mem_req) w_next = (WAIT_CYCLES == 0) ? RVM_MEMR_RESP : RVM_MEMR_WAIT;
      RVM_MEMR_WAIT: if (r_cnt == WAIT_LAST) w_next = RVM_MEMR_RESP;
      RVM_MEMR_RESP: begin
        mem_ack = 1'b1;
        w_next  = RVM_MEMR_IDLE;
      end
      default:       w_next = RVM_MEMR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_rd_ok <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_idle && mem_req) begin
        r_wen   <= mem_wen;
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_strb  <= mem_strb;
      end
      if (w_idle && w_next == RVM_MEMR_WAIT) r_cnt <= 8'd1;
      else if (r_state == RVM_MEMR_WAIT)     r_cnt <= (r_cnt == WAIT_LAST) ? 8'd0 : r_cnt + 8'd1;
      if (w_commit) begin
        r_rd_ok <= !w_wen && !w_err;
        r_err   <= w_err;
      end else if (r_state == RVM_MEMR_RESP) begin
        r_rd_ok <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  rvm_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .i_en    (w_commit && !w_err),
    .i_we    (w_wen),
    .i_idx   (w_offset[AW+1:2]),
    .i_wdata (w_wdata),
    .i_strb  (w_strb),
    .o_rdata (w_q)
  );

  assign mem_rdata = r_rd_ok ? w_q : '0;
  assign mem_error = r_err;

`ifdef RVM_SIM_ASSERT
  a_req_held: assert property (@(posedge clk) disable iff (!resetn)
    (r_state == RVM_MEMR_WAIT) |-> mem_req);
`endif

endmodule
